// File: rtl/reaction_game_ctrl.sv
// Reaction-time game controller: random wait, timed green phase, best score over ROUNDS.
// Optional: define FALSE_START_EN to add a FOUL state for hits during the wait.

module reaction_game_ctrl #(
  parameter int SCORE_W = 13,
  parameter int DELAY_W = 10,
  parameter int ROUNDS  = 4
) (
  input  logic               Clock,
  input  logic               CLRN,
  input  logic               tick,
  input  logic               buttonStart,
  input  logic               buttonHit,
  input  logic               buttonReset,
  input  logic [DELAY_W-1:0] delaySeed,
  output logic               RedLed,
  output logic               ledGreen,
  output logic [SCORE_W-1:0] DisplayScore,
  output logic [1:0]         DisplayScoreControl,
  output logic [3:0]         roundNum,
  output logic               done
);

`ifdef FALSE_START_EN
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_GO, S_RESULT, S_DONE, S_FOUL
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_GO, S_RESULT, S_DONE
  } state_e;
`endif

  localparam logic [3:0]         ROUNDS_L = 4'(ROUNDS);
  localparam logic [DELAY_W-1:0] D_ONE    = DELAY_W'(1);

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic [SCORE_W-1:0] cap;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [3:0]         round_q, round_d;
  logic               st_prev_q, hit_prev_q;
  logic               st_arm_q, hit_arm_q;
  logic               start_e, hit_e, sat;
  logic               go_wait, go_result;

  // arm bits block an edge from a button already held at reset release
  assign start_e  = buttonStart & ~st_prev_q & st_arm_q;
  assign hit_e    = buttonHit & ~hit_prev_q & hit_arm_q;
  assign sat      = &score_q;
  assign roundNum = round_q;

  always_ff @(posedge Clock or negedge CLRN) begin
    if (!CLRN) begin
      state_q    <= S_IDLE;
      score_q    <= '0;
      best_q     <= '1;
      delay_q    <= '0;
      round_q    <= '0;
      st_prev_q  <= 1'b0;
      hit_prev_q <= 1'b0;
      st_arm_q   <= 1'b0;
      hit_arm_q  <= 1'b0;
    end else if (buttonReset) begin
      state_q    <= S_IDLE;
      score_q    <= '0;
      best_q     <= '1;
      delay_q    <= '0;
      round_q    <= '0;
      st_prev_q  <= 1'b0;
      hit_prev_q <= 1'b0;
      st_arm_q   <= 1'b0;
      hit_arm_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      best_q     <= best_d;
      delay_q    <= delay_d;
      round_q    <= round_d;
      st_prev_q  <= buttonStart;
      hit_prev_q <= buttonHit;
      st_arm_q   <= st_arm_q | ~buttonStart;
      hit_arm_q  <= hit_arm_q | ~buttonHit;
    end
  end

  always_comb begin
    state_d             = state_q;
    score_d             = score_q;
    best_d              = best_q;
    delay_d             = delay_q;
    round_d             = round_q;
    cap                 = score_q;
    go_wait             = 1'b0;
    go_result           = 1'b0;
    RedLed              = 1'b0;
    ledGreen            = 1'b0;
    DisplayScore        = '0;
    DisplayScoreControl = 2'b00;
    done                = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_e) go_wait = 1'b1;
      end
      S_WAIT: begin
        RedLed = 1'b1;
        if (tick) begin
          delay_d = delay_q - 1'b1;
          if (delay_q <= D_ONE) state_d = S_GO;
        end
`ifdef FALSE_START_EN
        if (hit_e && !start_e) state_d = S_FOUL;
`endif
      end
      S_GO: begin
        ledGreen     = 1'b1;
        DisplayScore = score_q;
        // a tick landing with the hit still counts
        if (tick && !sat) cap = score_q + 1'b1;
        score_d = cap;
        if (hit_e || sat) go_result = 1'b1;
      end
      S_RESULT: begin
        DisplayScore = score_q;
        if (start_e) begin
          if (round_q == ROUNDS_L) state_d = S_DONE;
          else go_wait = 1'b1;
        end
      end
      S_DONE: begin
        done                = 1'b1;
        DisplayScoreControl = 2'b01;
        DisplayScore        = best_q;
        if (start_e) begin
          round_d = '0;
          go_wait = 1'b1;
        end
      end
`ifdef FALSE_START_EN
      S_FOUL: begin
        RedLed              = 1'b1;
        ledGreen            = 1'b1;
        DisplayScoreControl = 2'b10;
        if (start_e) go_wait = 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (go_wait) begin
      state_d = S_WAIT;
      score_d = '0;
      delay_d = (delaySeed == '0) ? D_ONE : delaySeed;
    end
    if (go_result) begin
      state_d = S_RESULT;
      score_d = cap;
      round_d = round_q + 4'd1;
      if (cap < best_q) best_d = cap;
    end
  end

endmodule

// File: doc/reaction_game_ctrl.md
REACTION_GAME_CTRL -- requirements
Module: reaction_game_ctrl

Interface
REQ-001 SHALL have parameter SCORE_W, default 13: width of the score counter and the best-score register.
REQ-002 SHALL have parameter DELAY_W, default 10: width of the random-delay counter.
REQ-003 SHALL have parameter ROUNDS, default 4: number of scored rounds per game (1..15).
REQ-004 SHALL have port Clock, in, 1: single clock; all state changes on the rising edge.
REQ-005 SHALL have port CLRN, in, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port tick, in, 1: 1 ms time-base enable, one Clock cycle wide.
REQ-007 SHALL have port buttonStart, in, 1: start request, level, edge-detected internally.
REQ-008 SHALL have port buttonHit, in, 1: player hit, level, edge-detected internally.
REQ-009 SHALL have port buttonReset, in, 1: synchronous full game reset.
REQ-010 SHALL have port delaySeed, in, DELAY_W: wait length in ticks, sampled on entry to WAIT.
REQ-011 SHALL have port RedLed, out, 1: asserted while waiting.
REQ-012 SHALL have port ledGreen, out, 1: asserted while timing.
REQ-013 SHALL have port DisplayScore, out, SCORE_W: value selected for display.
REQ-014 SHALL have port DisplayScoreControl, out, 2: 00 = live/last score, 01 = best score, 10 = foul.
REQ-015 SHALL have port roundNum, out, 4: completed scored rounds.
REQ-016 SHALL have port done, out, 1: asserted in DONE.

Function
REQ-017 SHALL detect a button edge as current & ~previous, with the previous value registered; one edge is acted on exactly once.
REQ-018 SHALL implement states IDLE, WAIT, GO, RESULT, FOUL and DONE as a registered state machine.
REQ-019 IDLE: both LEDs off, control 00, display 0; a start edge moves to WAIT.
REQ-020 Entry to WAIT: load the delay counter with delaySeed, using 1 if delaySeed is 0, and clear the score counter.
REQ-021 WAIT: RedLed=1; decrement on tick; when the counter reaches 0, the next state is GO; start edges are ignored.
REQ-022 GO: ledGreen=1; the score counter increments on tick and DisplayScore shows the live count.
REQ-023 GO, hit edge: move to RESULT and capture the score, including a tick occurring in the same cycle.
REQ-024 GO, score at 2^SCORE_W-1: hold that value (saturate) and move to RESULT without a hit.
REQ-025 Entry to RESULT: increment roundNum; if the captured score is strictly less than the best score, write it to the best register in the same cycle.
REQ-026 RESULT: LEDs off, control 00, display the captured score.
REQ-027 RESULT, start edge: if roundNum == ROUNDS, move to DONE, otherwise move to WAIT.
REQ-028 DONE: done=1, control 01, display the best score; a start edge moves to WAIT with roundNum cleared and the best score kept.
REQ-029 Hit edges SHALL be ignored in IDLE, RESULT, DONE and FOUL.
REQ-030 Simultaneous start and hit edges: hit wins in GO; start wins elsewhere.
REQ-031 buttonReset SHALL have priority over every other input and force the reset state of REQ-032 on the next edge.

Reset
REQ-032 CLRN low SHALL immediately force state IDLE, score 0, delay counter 0, roundNum 0, best score all-ones, edge registers 0, and all LEDs, done and control low.
REQ-033 After CLRN deasserts, a button held high SHALL NOT produce an edge until it has been seen low.

Configuration
REQ-034 With macro FALSE_START_EN defined, a hit edge in WAIT SHALL move to FOUL: both LEDs on, control 10, display 0, roundNum unchanged; a start edge in FOUL moves to WAIT.
REQ-035 Without FALSE_START_EN, the FOUL state SHALL NOT exist and hit edges in WAIT SHALL be ignored.

Verification
REQ-036 Reset, start, delaySeed=5, tick every 10 cycles, hit 3 ticks after green -> RedLed held for 5 ticks, DisplayScore=3, best=3, roundNum=1.
REQ-037 delaySeed=0 -> GO is reached after exactly 1 tick.
REQ-038 SCORE_W=4 with no hit -> score saturates at 15 and the block enters RESULT automatically.
REQ-039 ROUNDS=2 with scores 7 then 4 -> DONE, done=1, control 01, display 4; a further start clears roundNum and keeps best=4.
REQ-040 FALSE_START_EN defined, hit during WAIT -> FOUL, control 10, roundNum unchanged; without the macro -> stays in WAIT.
REQ-041 CLRN pulsed low mid-GO and buttonReset asserted mid-RESULT -> IDLE, best all-ones, outputs as in REQ-032.
